uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 20 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo.sv | 112 +++++++++++
 tb/tb_uart_tx_fifo.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter: FSM state
// encoding, frame geometry and a counter-width helper.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    // A counter must reach n-1; keep at least one bit when n is 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; a write while full is accepted
// only when a read frees a slot on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in sync_fifo and are shifted out
// as 8N1 frames, each bit held for CLK_FREQ/BAUD_RATE cycles.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TXD,
    input  logic       TXD_write,
    input  logic       OVF_clear,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       done
);

    localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW        = cnt_width(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          pop;
    logic          bit_end;
    logic          drop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (TXD_write),
        .rd_en (pop),
        .din   (TXD),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bit_end = (baud == BAUD_LAST);
    // A pop on the same edge frees a slot, so only a truly blocked write drops.
    assign drop    = TXD_write && full && !pop;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx = shift[bit_idx];
                if (bit_end && (bit_idx == LAST_BIT)) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE || bit_end) baud <= '0;
            else                          baud <= baud + 1'b1;

            if (state == START)                bit_idx <= '0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;

            if (pop) shift <= head;

            done <= (state == STOP) && bit_end;

            if (drop)           overflow <= 1'b1;
            else if (OVF_clear) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based transmitter model predicts
// frame order, start cycles and flags; a line monitor decodes the tx waveform.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int unsigned CF = 1000000;
    localparam int unsigned BR = 100000;
    localparam int DV        = 10;
    localparam int DP        = 4;
    localparam int FRAME_CYC = FRAME_BITS * DV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] TXD = '0;
    logic       TXD_write = 1'b0;
    logic       OVF_clear = 1'b0;
    logic       tx, busy, full, empty, overflow, done;

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .TXD(TXD), .TXD_write(TXD_write),
        .OVF_clear(OVF_clear), .tx(tx), .busy(busy), .full(full),
        .empty(empty), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         start;
        bit         ok;
    } frame_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: byte queue plus the earliest edge the transmitter may pop.
    logic [7:0] mq[$];
    frame_t     exp_q[$];
    frame_t     rx_q[$];
    int         m_next_pop = 0;
    bit         m_ovf = 0;
    bit         m_pop, m_drop;
    frame_t     m_f;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_next_pop = 0;
            m_ovf = 0;
        end else begin
            m_pop  = (mq.size() > 0) && (cyc >= m_next_pop);
            m_drop = 0;
            if (m_pop) begin
                m_f.b = mq.pop_front();
                m_f.start = cyc;
                m_f.ok = 1;
                exp_q.push_back(m_f);
                m_next_pop = cyc + FRAME_CYC + 1;
            end
            if (TXD_write) begin
                if (mq.size() < DP) mq.push_back(TXD);
                else m_drop = 1;
            end
            if (m_drop) m_ovf = 1;
            else if (OVF_clear) m_ovf = 0;
        end
    end

    // Line monitor: decodes each frame and flags any level, busy or done error.
    bit     mon_in = 0;
    int     mon_start, mon_off, mon_idx;
    frame_t mon_f;
    int     frames_seen = 0;
    int     done_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            mon_in = 0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (!mon_in && tx === 1'b0) begin
                mon_in = 1;
                mon_start = cyc;
                mon_f.b = '0;
                mon_f.start = cyc;
                mon_f.ok = 1;
            end
            if (mon_in) begin
                mon_off = cyc - mon_start;
                if (mon_off < FRAME_CYC) begin
                    if (busy !== 1'b1 || done !== 1'b0) mon_f.ok = 0;
                    if (mon_off < DV) begin
                        if (tx !== 1'b0) mon_f.ok = 0;
                    end else if (mon_off >= FRAME_CYC - DV) begin
                        if (tx !== 1'b1) mon_f.ok = 0;
                    end else begin
                        mon_idx = mon_off / DV - 1;
                        if (mon_off % DV == 0) mon_f.b[mon_idx] = tx;
                        else if (tx !== mon_f.b[mon_idx]) mon_f.ok = 0;
                    end
                end else begin
                    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) mon_f.ok = 0;
                    rx_q.push_back(mon_f);
                    frames_seen++;
                    mon_in = 0;
                end
            end
        end
    end

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && busy === 1'b0 && !mon_in && rx_q.size() == exp_q.size()) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx, busy, done, overflow, empty, full} !== 6'b100010) begin
            fails++;
            $display("FAIL reset_state: got tx/busy/done/ovf/empty/full=%b want 100010",
                     {tx, busy, done, overflow, empty, full});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] b;
        int wc;
        bit ok;
        frame_t e, r;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom);
            wc = cyc;
            TXD = b; TXD_write = 1'b1;
            @(negedge clk);
            TXD_write = 1'b0;
            tests++;
            if (empty !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL single_enqueue: got empty=%b busy=%b want 0 0", empty, busy);
            end
            @(negedge clk);
            tests++;
            if ({busy, tx, empty} !== 3'b101) begin
                fails++;
                $display("FAIL single_pop: got busy/tx/empty=%b want 101", {busy, tx, empty});
            end
            wait_drain(ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL single_drain: timeout got 0 want 1"); end
            tests++;
            if (rx_q.size() != 1 || rx_q[0].start != wc + 2 || rx_q[0].b !== b || !rx_q[0].ok) begin
                fails++;
                $display("FAIL single_frame: got %0d frames, first start %0d want 1 frame byte %h start %0d",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[0].start : -1, b, wc + 2);
            end
            while (exp_q.size() > 0 && rx_q.size() > 0) begin
                e = exp_q.pop_front(); r = rx_q.pop_front();
                tests++;
                if (r.b !== e.b || r.start != e.start || !r.ok) begin
                    fails++;
                    $display("FAIL single_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
                end
            end
        end
    endtask

    task automatic test_burst();
        bit ok;
        frame_t e, r;
        for (int i = 1; i <= 5; i++) begin
            TXD = 8'(i); TXD_write = 1'b1;
            @(negedge clk);
        end
        TXD_write = 1'b0;
        tests++;
        if ({full, overflow} !== 2'b10) begin
            fails++;
            $display("FAIL burst_full: got full/ovf=%b want 10", {full, overflow});
        end
        wait_drain(ok);
        tests++;
        if (!ok || rx_q.size() != 5) begin
            fails++;
            $display("FAIL burst_count: got %0d frames want 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (rx_q[i].b !== 8'(i + 1) || (i > 0 && rx_q[i].start - rx_q[i-1].start != FRAME_CYC + 1)) begin
                    fails++;
                    $display("FAIL burst_spacing: frame %0d got %h want %h, spacing want %0d",
                             i, rx_q[i].b, 8'(i + 1), FRAME_CYC + 1);
                end
            end
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            tests++;
            if (r.b !== e.b || r.start != e.start || !r.ok) begin
                fails++;
                $display("FAIL burst_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
            end
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL burst_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        bit ok;
        frame_t e, r;
        for (int i = 0; i < 6; i++) begin
            TXD = 8'($urandom); TXD_write = 1'b1;
            @(negedge clk);
        end
        TXD_write = 1'b0;
        tests++;
        if (overflow !== 1'b1 || m_ovf !== 1'b1 || full !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got ovf=%b full=%b want 1 1", overflow, full);
        end
        // drop and clear together: set wins
        TXD = 8'hEE; TXD_write = 1'b1; OVF_clear = 1'b1;
        @(negedge clk);
        TXD_write = 1'b0; OVF_clear = 1'b0;
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_priority: got %b want 1", overflow); end
        OVF_clear = 1'b1;
        @(negedge clk);
        OVF_clear = 1'b0;
        tests++;
        if (overflow !== 1'b0 || m_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        wait_drain(ok);
        tests++;
        if (!ok || rx_q.size() != 5) begin
            fails++;
            $display("FAIL ovf_frames: got %0d frames want 5", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            tests++;
            if (r.b !== e.b || r.start != e.start || !r.ok) begin
                fails++;
                $display("FAIL ovf_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
            end
        end
    endtask

    task automatic test_full_pop();
        bit ok, seen;
        frame_t e, r;
        for (int i = 0; i < 5; i++) begin
            TXD = 8'($urandom); TXD_write = 1'b1;
            @(negedge clk);
        end
        TXD_write = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen || full !== 1'b1) begin
            fails++;
            $display("FAIL fullpop_setup: got done_seen=%0d full=%b want 1 1", seen, full);
        end
        TXD = 8'($urandom); TXD_write = 1'b1;
        @(negedge clk);
        TXD_write = 1'b0;
        tests++;
        if ({full, overflow, busy} !== 3'b101 || mq.size() != DP) begin
            fails++;
            $display("FAIL fullpop_accept: got full/ovf/busy=%b want 101", {full, overflow, busy});
        end
        wait_drain(ok);
        tests++;
        if (!ok || rx_q.size() != 6) begin
            fails++;
            $display("FAIL fullpop_frames: got %0d frames want 6", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            tests++;
            if (r.b !== e.b || r.start != e.start || !r.ok) begin
                fails++;
                $display("FAIL fullpop_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wc, dc;
        bit ok;
        frame_t e, r;
        wc = cyc;
        for (int i = 0; i < 3; i++) begin
            TXD = 8'($urandom) & 8'hF7; TXD_write = 1'b1;
            @(negedge clk);
        end
        TXD_write = 1'b0;
        while (cyc < wc + 2 + 4 * DV + DV / 2) @(negedge clk);
        tests++;
        if ({tx, busy, empty} !== 3'b010) begin
            fails++;
            $display("FAIL midreset_pre: got tx/busy/empty=%b want 010", {tx, busy, empty});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({tx, busy, empty, full, done} !== 5'b10100) begin
            fails++;
            $display("FAIL midreset_abort: got tx/busy/empty/full/done=%b want 10100", {tx, busy, empty, full, done});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dc = done_cnt;
        repeat (150) @(negedge clk);
        tests++;
        if (done_cnt != dc || rx_q.size() != 0 || tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: got done pulses %0d frames %0d want 0 0", done_cnt - dc, rx_q.size());
        end
        TXD = 8'($urandom); TXD_write = 1'b1;
        @(negedge clk);
        TXD_write = 1'b0;
        wait_drain(ok);
        tests++;
        if (!ok || rx_q.size() != 1) begin
            fails++;
            $display("FAIL midreset_resume: got %0d frames want 1", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            tests++;
            if (r.b !== e.b || r.start != e.start || !r.ok) begin
                fails++;
                $display("FAIL midreset_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        frame_t e, r;
        for (int i = 0; i < 600; i++) begin
            tests++;
            if (full !== (mq.size() == DP) || empty !== (mq.size() == 0) || overflow !== m_ovf) begin
                fails++;
                $display("FAIL random_flags: cycle %0d got full/empty/ovf=%b%b%b want %b%b%b", cyc,
                         full, empty, overflow, mq.size() == DP, mq.size() == 0, m_ovf);
            end
            TXD = 8'($urandom);
            TXD_write = ($urandom_range(0, 24) == 0);
            OVF_clear = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        TXD_write = 1'b0; OVF_clear = 1'b0;
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL random_drain: timeout got 0 want 1"); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            tests++;
            if (r.b !== e.b || r.start != e.start || !r.ok) begin
                fails++;
                $display("FAIL random_model: got %h@%0d ok=%0d want %h@%0d", r.b, r.start, r.ok, e.b, e.start);
            end
        end
        tests++;
        if (rx_q.size() != 0 || exp_q.size() != 0 || done_cnt != frames_seen) begin
            fails++;
            $display("FAIL random_leftover: got rx %0d exp %0d done %0d frames %0d want 0 0 equal",
                     rx_q.size(), exp_q.size(), done_cnt, frames_seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
